unpooler: RTL and testbench

Nearest-neighbour upsampling stage, the inverse of the max-pool stage. Consumes a pooled feature-map stream of (M/P)×(M/P) 32-bit words in raster order and emits the full M×M raster stream. Each pooled value is replicated across its P×P window. Sits on the decoder/deconvolution side of the accelerator datapath and produces the same valid_op/end_op stream format that the pooling stage consumes and emits.

---
 rtl/unpool_pkg.sv | 20 ++
 rtl/unpool_line_buf.sv | 28 ++
 rtl/unpooler.sv | 177 +++++++++++++++++
 tb/tb_unpooler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unpool_pkg.sv
// Shared types and defaults for the unpooler (nearest-neighbour upsampler).
// Optional build macro: UNPOOL_ZERO_FILL_EN selects sparse max-unpooling.
package unpool_pkg;

    typedef enum logic [0:0] {
        LOAD   = 1'b0,
        REPLAY = 1'b1
    } unpool_state_e;

    localparam int DEF_M  = 12;
    localparam int DEF_P  = 3;
    localparam int DEF_DW = 32;
    localparam int DEF_N  = DEF_M / DEF_P;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unpool_line_buf.sv
// One pooled row of values, written while a window row is loaded and read back
// for the replayed sub-rows. Storage is deliberately not reset.
module unpool_line_buf
    import unpool_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int AW = cnt_w(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/unpooler.sv
// Upsamples an (M/P)x(M/P) raster stream to MxM by replicating each value over its PxP window.
// Define UNPOOL_ZERO_FILL_EN for sparse unpooling (value at window top-left, zeros elsewhere).
module unpooler
    import unpool_pkg::*;
#(
    parameter int M  = DEF_M,
    parameter int P  = DEF_P,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          master_rst,
    input  logic          ce,
    input  logic [DW-1:0] data_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] data_out,
    output logic          valid_op,
    output logic          end_op
);

    localparam int N  = M / P;
    localparam int CW = cnt_w(P);
    localparam int AW = cnt_w(N);

    localparam logic [CW-1:0] CREP_MAX = CW'(P - 1);
    localparam logic [AW-1:0] POS_MAX  = AW'(N - 1);

    if (P < 1 || (M % P) != 0) begin : g_bad_cfg
        $error("unpooler: M must be a positive multiple of P");
    end

    unpool_state_e state_q, state_d;
    logic [CW-1:0] crep_q, crep_d;
    logic [AW-1:0] col_q, col_d;
    logic [CW-1:0] srow_q, srow_d;
    logic [AW-1:0] row_q, row_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          valid_op_q, valid_op_d;
    logic          end_op_q, end_op_d;
    // Holds in_ready low for the first cycle after reset so reset reads as not-ready.
    logic          rdy_q, rdy_d;

    logic          crep_last, col_last, srow_last, row_last;
    logic          fire;
    logic          emit;
    logic [DW-1:0] beat_val;

    assign crep_last = (crep_q == CREP_MAX);
    assign col_last  = (col_q == POS_MAX);
    assign srow_last = (srow_q == CREP_MAX);
    assign row_last  = (row_q == POS_MAX);

    assign in_ready = ce & ~master_rst & rdy_q & (state_q == LOAD) & (crep_q == '0);
    assign fire     = in_valid & in_ready;

`ifdef UNPOOL_ZERO_FILL_EN
    always_comb begin
        emit     = 1'b0;
        beat_val = '0;
        if (state_q == LOAD) begin
            if (crep_q == '0) begin
                emit     = fire;
                beat_val = data_in;
            end else begin
                emit = ce;
            end
        end else begin
            emit = ce;
        end
    end
`else
    logic [DW-1:0] hold_q, hold_d;
    logic [DW-1:0] lb_rd_data;

    unpool_line_buf #(
        .N  (N),
        .DW (DW),
        .AW (AW)
    ) u_line_buf (
        .clk     (clk),
        .we      (fire),
        .wr_addr (col_q),
        .wr_data (data_in),
        .rd_addr (col_q),
        .rd_data (lb_rd_data)
    );

    always_comb begin
        hold_d = fire ? data_in : hold_q;
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    always_comb begin
        emit     = 1'b0;
        beat_val = '0;
        if (state_q == LOAD) begin
            if (crep_q == '0) begin
                emit     = fire;
                beat_val = data_in;
            end else begin
                emit     = ce;
                beat_val = hold_q;
            end
        end else begin
            emit     = ce;
            beat_val = lb_rd_data;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        crep_d     = crep_q;
        col_d      = col_q;
        srow_d     = srow_q;
        row_d      = row_q;
        data_out_d = data_out_q;
        valid_op_d = 1'b0;
        end_op_d   = 1'b0;
        rdy_d      = 1'b1;

        if (emit) begin
            data_out_d = beat_val;
            valid_op_d = 1'b1;
            end_op_d   = crep_last & col_last & srow_last & row_last;

            crep_d = crep_last ? '0 : crep_q + 1'b1;
            if (crep_last) begin
                col_d = col_last ? '0 : col_q + 1'b1;
                if (col_last) begin
                    srow_d = srow_last ? '0 : srow_q + 1'b1;
                    // With P == 1 srow_last is always true, so REPLAY is never entered.
                    state_d = srow_last ? LOAD : REPLAY;
                    if (srow_last) begin
                        row_d = row_last ? '0 : row_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            state_q    <= LOAD;
            crep_q     <= '0;
            col_q      <= '0;
            srow_q     <= '0;
            row_q      <= '0;
            data_out_q <= '0;
            valid_op_q <= 1'b0;
            end_op_q   <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            crep_q     <= crep_d;
            col_q      <= col_d;
            srow_q     <= srow_d;
            row_q      <= row_d;
            data_out_q <= data_out_d;
            valid_op_q <= valid_op_d;
            end_op_q   <= end_op_d;
            rdy_q      <= rdy_d;
        end
    end

    assign data_out = data_out_q;
    assign valid_op = valid_op_q;
    assign end_op   = end_op_q;

endmodule

// File: tb/tb_unpooler.sv
// Directed bench for unpooler at M=12, P=3; build with UNPOOL_ZERO_FILL_EN to check sparse mode.
module tb_unpooler;

  localparam int M  = 12;
  localparam int P  = 3;
  localparam int N  = M / P;
  localparam int DW = 32;
  localparam int FB = M * M;

  logic          clk = 1'b0;
  logic          master_rst;
  logic          ce;
  logic [DW-1:0] data_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          valid_op;
  logic          end_op;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] got_d[$];
  bit            got_e[$];
  bit            cyc_valid[$];
  bit            cyc_fire[$];
  bit            cyc_ce[$];

  logic [DW-1:0] gap_val;
  int            gap_left;
  int            stall_at;
  int            stall_left;

  always #5 clk = ~clk;

  unpooler #(.M(M), .P(P), .DW(DW)) dut (
    .clk        (clk),
    .master_rst (master_rst),
    .ce         (ce),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .valid_op   (valid_op),
    .end_op     (end_op)
  );

  // Expected value of beat b (0-based, may span frames) when inputs are base, base+1, ...
  function automatic logic [DW-1:0] exp_beat(input int b, input int base);
    int f, r, x, idx;
    f   = b / FB;
    r   = (b % FB) / M;
    x   = b % M;
    idx = f * N * N + (r / P) * N + (x / P);
`ifdef UNPOOL_ZERO_FILL_EN
    if ((r % P) != 0 || (x % P) != 0) return '0;
`endif
    return DW'(base + idx);
  endfunction

  task automatic clear_logs();
    got_d.delete();
    got_e.delete();
    cyc_valid.delete();
    cyc_fire.delete();
    cyc_ce.delete();
    gap_left   = 0;
    stall_left = 0;
    stall_at   = -1;
    gap_val    = '0;
  endtask

  task automatic push_inputs(input int first, input int count);
    for (int i = 0; i < count; i++) src_q.push_back(DW'(first + i));
  endtask

  // One clock: drive ce/in_valid, commit the handshake at the edge, record outputs.
  task automatic step();
    bit fire;
    bit gap_now;
    ce = !(stall_left > 0 && got_d.size() == stall_at);
    if (!ce) stall_left--;
    #1;
    gap_now = gap_left > 0 && src_q.size() > 0 && src_q[0] == gap_val && in_ready;
    if (gap_now) gap_left--;
    if (src_q.size() > 0 && !gap_now) begin
      in_valid = 1'b1;
      data_in  = src_q[0];
    end else begin
      in_valid = 1'b0;
      data_in  = '0;
    end
    #1;
    fire = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (fire) void'(src_q.pop_front());
    cyc_fire.push_back(fire);
    cyc_ce.push_back(ce);
    cyc_valid.push_back(valid_op);
    if (valid_op) begin
      got_d.push_back(data_out);
      got_e.push_back(end_op);
    end
  endtask

  task automatic run_beats(input int nb, input int budget);
    int c;
    c = 0;
    while (got_d.size() < nb && c < budget) begin
      step();
      c++;
    end
    in_valid = 1'b0;
    ce       = 1'b1;
  endtask

  task automatic test_reset();
    master_rst = 1'b1;
    ce         = 1'b1;
    in_valid   = 1'b1;
    data_in    = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got=%0h exp=0", data_out); end
    n_cmp++; if (valid_op !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_op); end
    n_cmp++; if (end_op !== 1'b0) begin n_fail++; $display("FAIL reset_end got=%b exp=0", end_op); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst got=%b exp=0", in_ready); end
    master_rst = 1'b0;
    in_valid   = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_after got=%b exp=0", in_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_armed got=%b exp=1", in_ready); end
  endtask

  task automatic test_frame_basic();
    logic [DW-1:0] row0 [M];
    int first_fire;
    int fires;
`ifdef UNPOOL_ZERO_FILL_EN
    row0 = '{32'd1, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd4, 32'd0, 32'd0};
`else
    row0 = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'd3, 32'd3, 32'd4, 32'd4, 32'd4};
`endif
    clear_logs();
    push_inputs(1, 16);
    run_beats(FB, 400);
    n_cmp++; if (got_d.size() !== FB) begin n_fail++; $display("FAIL basic_count got=%0d exp=%0d", got_d.size(), FB); end
    for (int i = 0; i < M && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== row0[i]) begin n_fail++; $display("FAIL basic_row0[%0d] got=%0d exp=%0d", i, got_d[i], row0[i]); end
    end
    for (int i = 0; i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_beat(i, 1)) begin n_fail++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, got_d[i], exp_beat(i, 1)); end
      n_cmp++; if (got_e[i] !== (i == FB - 1)) begin n_fail++; $display("FAIL basic_end[%0d] got=%b exp=%b", i, got_e[i], i == FB - 1); end
    end
    first_fire = -1;
    fires = 0;
    for (int i = 0; i < cyc_fire.size(); i++) begin
      if (cyc_fire[i]) begin
        fires++;
        if (first_fire < 0) first_fire = i;
      end
    end
    n_cmp++; if (fires !== 16) begin n_fail++; $display("FAIL basic_handshakes got=%0d exp=16", fires); end
    n_cmp++;
    if (first_fire < 0 || cyc_valid[first_fire] !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency first_fire_cycle=%0d valid_after_edge exp=1", first_fire);
    end
  endtask

  task automatic test_bubbles();
    int first_v, last_v, bubbles;
    clear_logs();
    gap_val  = 32'd2;
    gap_left = 5;
    push_inputs(1, 16);
    run_beats(FB, 400);
    n_cmp++; if (got_d.size() !== FB) begin n_fail++; $display("FAIL bubble_count got=%0d exp=%0d", got_d.size(), FB); end
    first_v = -1;
    last_v  = -1;
    for (int i = 0; i < cyc_valid.size(); i++) begin
      if (cyc_valid[i]) begin
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    bubbles = 0;
    for (int i = first_v; i >= 0 && i <= last_v; i++) if (!cyc_valid[i]) bubbles++;
    n_cmp++; if (bubbles !== 5) begin n_fail++; $display("FAIL bubble_cycles got=%0d exp=5", bubbles); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_beat(i, 1)) begin n_fail++; $display("FAIL bubble_data[%0d] got=%0d exp=%0d", i, got_d[i], exp_beat(i, 1)); end
      n_cmp++; if (got_e[i] !== (i == FB - 1)) begin n_fail++; $display("FAIL bubble_end[%0d] got=%b exp=%b", i, got_e[i], i == FB - 1); end
    end
  endtask

  task automatic test_ce_stall();
    int low_cycles, low_valid;
    clear_logs();
    stall_at   = 16;
    stall_left = 4;
    push_inputs(1, 16);
    run_beats(FB, 400);
    n_cmp++; if (got_d.size() !== FB) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", got_d.size(), FB); end
    low_cycles = 0;
    low_valid  = 0;
    for (int i = 0; i < cyc_ce.size(); i++) begin
      if (!cyc_ce[i]) begin
        low_cycles++;
        if (cyc_valid[i]) low_valid++;
      end
    end
    n_cmp++; if (low_cycles !== 4) begin n_fail++; $display("FAIL stall_ce_cycles got=%0d exp=4", low_cycles); end
    n_cmp++; if (low_valid !== 0) begin n_fail++; $display("FAIL stall_valid_while_frozen got=%0d exp=0", low_valid); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_beat(i, 1)) begin n_fail++; $display("FAIL stall_data[%0d] got=%0d exp=%0d", i, got_d[i], exp_beat(i, 1)); end
      n_cmp++; if (got_e[i] !== (i == FB - 1)) begin n_fail++; $display("FAIL stall_end[%0d] got=%b exp=%b", i, got_e[i], i == FB - 1); end
    end
  endtask

  task automatic test_midframe_reset();
    clear_logs();
    push_inputs(1, 16);
    run_beats(50, 200);
    n_cmp++; if (got_d.size() !== 50) begin n_fail++; $display("FAIL rst_pre_count got=%0d exp=50", got_d.size()); end
    master_rst = 1'b1;
    ce         = 1'b1;
    in_valid   = 1'b1;
    data_in    = 32'd77;
    @(posedge clk);
    #1;
    n_cmp++; if (data_out !== '0) begin n_fail++; $display("FAIL rst_mid_data got=%0d exp=0", data_out); end
    n_cmp++; if (valid_op !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", valid_op); end
    n_cmp++; if (end_op !== 1'b0) begin n_fail++; $display("FAIL rst_mid_end got=%b exp=0", end_op); end
    master_rst = 1'b0;
    in_valid   = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=0", in_ready); end
    src_q.delete();
    clear_logs();
    push_inputs(100, 16);
    run_beats(FB, 400);
    n_cmp++; if (got_d.size() !== FB) begin n_fail++; $display("FAIL rst_post_count got=%0d exp=%0d", got_d.size(), FB); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_beat(i, 100)) begin n_fail++; $display("FAIL rst_post_data[%0d] got=%0d exp=%0d", i, got_d[i], exp_beat(i, 100)); end
      n_cmp++; if (got_e[i] !== (i == FB - 1)) begin n_fail++; $display("FAIL rst_post_end[%0d] got=%b exp=%b", i, got_e[i], i == FB - 1); end
    end
  endtask

  task automatic test_back_to_back();
    int first_v, last_v, gaps;
    clear_logs();
    push_inputs(1, 32);
    run_beats(2 * FB, 800);
    n_cmp++; if (got_d.size() !== 2 * FB) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", got_d.size(), 2 * FB); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_beat(i, 1)) begin n_fail++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, got_d[i], exp_beat(i, 1)); end
      n_cmp++; if (got_e[i] !== (i == FB - 1 || i == 2 * FB - 1)) begin n_fail++; $display("FAIL b2b_end[%0d] got=%b", i, got_e[i]); end
    end
    if (got_d.size() > FB) begin
      n_cmp++; if (got_d[FB] !== 32'd17) begin n_fail++; $display("FAIL b2b_beat145 got=%0d exp=17", got_d[FB]); end
    end
    first_v = -1;
    last_v  = -1;
    for (int i = 0; i < cyc_valid.size(); i++) begin
      if (cyc_valid[i]) begin
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    gaps = 0;
    for (int i = first_v; i >= 0 && i <= last_v; i++) if (!cyc_valid[i]) gaps++;
    n_cmp++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_gap_cycles got=%0d exp=0", gaps); end
  endtask

  initial begin
    master_rst = 1'b1;
    ce         = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    clear_logs();
    test_reset();
    test_frame_basic();
    test_bubbles();
    test_ce_stall();
    test_midframe_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
